// File: rtl/game_pkg.sv
// Shared types and constants for the street-crossing game.
// Round states, BCD limits and default round settings.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    localparam logic [11:0] BCD_MAX = 12'h999;

    localparam int DEF_LIVES = 3;

    localparam logic [11:0] DEF_TIME_LIMIT_BCD = 12'h060;

    // Legal BCD orders the same as plain binary.
    function automatic logic bcd_lt(
        input logic [11:0] a,
        input logic [11:0] b
    );
        return a < b;
    endfunction

    // Lives never wrap below zero.
    function automatic logic [2:0] lives_dec(
        input logic [2:0] l
    );
        return (l == 3'd0) ? 3'd0 : l - 3'd1;
    endfunction

endpackage

// File: rtl/key_event.sv
// Pushbutton conditioner: 2-FF synchroniser plus rising-edge pulse.
// A held key yields a single one-cycle event.
module key_event (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key,
    output logic evt
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronise the raw key and keep one delayed copy for edge detect.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= key;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign evt = s2 & ~s3;

endmodule

// File: rtl/round_ctrl.sv
// Round supervisor: start/pause/win/lose FSM, lives, best time.
// Drives the BCD seconds counter enable and its clear pulse.
module round_ctrl
    import game_pkg::*;
#(
    parameter int          LIVES          = DEF_LIVES,
    parameter logic [11:0] TIME_LIMIT_BCD = DEF_TIME_LIMIT_BCD
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start_key,
    input  logic        pause_key,
    input  logic        hit,
    input  logic        goal,
    input  logic [11:0] time_bcd,
    output logic        count_en,
    output logic        count_clr_n,
    output logic        respawn,
    output logic [2:0]  lives,
    output logic [11:0] best_bcd,
    output logic [2:0]  state
);

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);

    state_t st;
    logic   start_evt;
    logic   pause_evt;
    logic   hit_q;
    logic   hit_evt;
    logic   timeout;

    key_event u_start (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .key      (start_key),
        .evt      (start_evt)
    );

    key_event u_pause (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .key      (pause_key),
        .evt      (pause_evt)
    );

    assign hit_evt = hit & ~hit_q;
    assign timeout = time_bcd >= TIME_LIMIT_BCD;
    assign state   = st;

    // Remember last hit level so a long overlap costs one life.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit;
        end
    end

    // Round FSM with registered counter controls, lives and best time.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            st          <= ST_IDLE;
            lives       <= 3'd0;
            best_bcd    <= BCD_MAX;
            count_en    <= 1'b0;
            count_clr_n <= 1'b0;
            respawn     <= 1'b0;
        end else begin
            respawn     <= 1'b0;
            count_clr_n <= 1'b1;
            count_en    <= 1'b0;
            unique case (st)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start_evt) begin
                        st          <= ST_RUN;
                        lives       <= LIVES_INIT;
                        count_clr_n <= 1'b0;
                        respawn     <= 1'b1;
                        count_en    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (goal) begin
                        st <= ST_WIN;
                        if (bcd_lt(time_bcd, best_bcd)) begin
                            best_bcd <= time_bcd;
                        end
                    end else if (hit_evt) begin
                        if (lives <= 3'd1) begin
                            lives <= 3'd0;
                            st    <= ST_LOSE;
                        end else begin
                            lives    <= lives_dec(lives);
                            respawn  <= 1'b1;
                            count_en <= 1'b1;
                        end
                    end else if (timeout) begin
                        st <= ST_LOSE;
                    end else if (pause_evt) begin
                        st <= ST_PAUSE;
                    end else begin
                        count_en <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (pause_evt) begin
                        st       <= ST_RUN;
                        count_en <= 1'b1;
                    end
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: directed round scenarios then random play.
// Every cycle is compared against a behavioural reference model.
module tb_round_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b0;
    logic        start_key = 1'b0;
    logic        pause_key = 1'b0;
    logic        hit = 1'b0;
    logic        goal = 1'b0;
    logic [11:0] time_bcd = 12'h010;
    logic        count_en;
    logic        count_clr_n;
    logic        respawn;
    logic [2:0]  lives;
    logic [11:0] best_bcd;
    logic [2:0]  state;

    int total = 0;
    int bad = 0;

    int          m_st;
    int          m_lives;
    logic [11:0] m_best;
    bit          m_en;
    bit          m_clr;
    bit          m_rsp;
    bit          sh[4];
    bit          ph[4];
    bit          m_hprev;

    always #10 CLOCK_50 = ~CLOCK_50;

    round_ctrl dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .start_key   (start_key),
        .pause_key   (pause_key),
        .hit         (hit),
        .goal        (goal),
        .time_bcd    (time_bcd),
        .count_en    (count_en),
        .count_clr_n (count_clr_n),
        .respawn     (respawn),
        .lives       (lives),
        .best_bcd    (best_bcd),
        .state       (state)
    );

    task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st = 0;
        m_lives = 0;
        m_best = 12'h999;
        m_en = 0;
        m_clr = 0;
        m_rsp = 0;
        m_hprev = 0;
        for (int i = 0; i < 4; i++) begin
            sh[i] = 0;
            ph[i] = 0;
        end
    endtask

    // One clock edge of the game rules.
    task automatic m_step();
        bit se;
        bit pe;
        bit he;
        if (!resetn) begin
            m_reset();
            return;
        end
        for (int i = 3; i > 0; i--) begin
            sh[i] = sh[i-1];
            ph[i] = ph[i-1];
        end
        sh[0] = start_key;
        ph[0] = pause_key;
        se = sh[2] && !sh[3];
        pe = ph[2] && !ph[3];
        he = hit && !m_hprev;
        m_hprev = hit;
        m_rsp = 0;
        m_clr = 1;
        if (m_st == 1) begin
            if (goal) begin
                m_st = 3;
                if (time_bcd < m_best) m_best = time_bcd;
            end else if (he) begin
                m_lives = m_lives - 1;
                if (m_lives <= 0) begin
                    m_lives = 0;
                    m_st = 4;
                end else begin
                    m_rsp = 1;
                end
            end else if (time_bcd >= 12'h060) begin
                m_st = 4;
            end else if (pe) begin
                m_st = 2;
            end
        end else if (m_st == 2) begin
            if (pe) m_st = 1;
        end else if (se) begin
            m_st = 1;
            m_lives = 3;
            m_clr = 0;
            m_rsp = 1;
        end
        m_en = (m_st == 1);
    endtask

    task automatic cmp();
        chk("state", 12'(state), 12'(m_st));
        chk("lives", 12'(lives), 12'(m_lives));
        chk("best", best_bcd, m_best);
        chk("en", 12'(count_en), 12'(m_en));
        chk("clr_n", 12'(count_clr_n), 12'(m_clr));
        chk("respawn", 12'(respawn), 12'(m_rsp));
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        m_step();
        @(negedge CLOCK_50);
        cmp();
    endtask

    task automatic press_start();
        start_key = 1'b1;
        repeat (4) cyc();
        start_key = 1'b0;
        cyc();
    endtask

    task automatic press_pause();
        pause_key = 1'b1;
        repeat (4) cyc();
        pause_key = 1'b0;
        cyc();
    endtask

    task automatic async_reset();
        resetn = 1'b0;
        #1;
        m_reset();
        chk("rst_state", 12'(state), 12'd0);
        chk("rst_en", 12'(count_en), 12'd0);
        chk("rst_best", best_bcd, 12'h999);
        chk("rst_lives", 12'(lives), 12'd0);
        chk("rst_clr", 12'(count_clr_n), 12'd0);
        chk("rst_rsp", 12'(respawn), 12'd0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    initial begin
        int nclr;
        int nrsp;
        int v;
        m_reset();
        @(negedge CLOCK_50);
        async_reset();
        repeat (3) cyc();

        // Start: held key, acts on the 3rd edge, single pulses.
        nclr = 0;
        nrsp = 0;
        start_key = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (!count_clr_n) nclr++;
            if (respawn) nrsp++;
            if (i == 1) chk("st_e2", 12'(state), 12'd0);
            if (i == 2) chk("st_e3", 12'(state), 12'd1);
        end
        start_key = 1'b0;
        chk("clr_pulses", 12'(nclr), 12'd1);
        chk("rsp_pulses", 12'(nrsp), 12'd1);
        chk("lives_init", 12'(lives), 12'd3);
        chk("en_run", 12'(count_en), 12'd1);

        // Win, then a slower win keeps the best time.
        time_bcd = 12'h023;
        goal = 1'b1;
        cyc();
        goal = 1'b0;
        chk("win1", 12'(state), 12'd3);
        chk("best1", best_bcd, 12'h023);
        time_bcd = 12'h010;
        press_start();
        time_bcd = 12'h031;
        goal = 1'b1;
        cyc();
        goal = 1'b0;
        time_bcd = 12'h010;
        chk("win2", 12'(state), 12'd3);
        chk("best2", best_bcd, 12'h023);

        // Hits: long hold counts once, last life loses.
        press_start();
        hit = 1'b1;
        cyc();
        chk("rsp_h1", 12'(respawn), 12'd1);
        repeat (99) cyc();
        chk("lives_h1", 12'(lives), 12'd2);
        hit = 1'b0;
        cyc();
        hit = 1'b1;
        cyc();
        chk("rsp_h2", 12'(respawn), 12'd1);
        chk("lives_h2", 12'(lives), 12'd1);
        hit = 1'b0;
        cyc();
        hit = 1'b1;
        cyc();
        chk("lives_h3", 12'(lives), 12'd0);
        chk("st_h3", 12'(state), 12'd4);
        chk("rsp_h3", 12'(respawn), 12'd0);
        hit = 1'b0;
        cyc();

        // Timeout at the limit, lives kept.
        press_start();
        time_bcd = 12'h059;
        repeat (3) cyc();
        chk("st_059", 12'(state), 12'd1);
        time_bcd = 12'h060;
        cyc();
        chk("st_060", 12'(state), 12'd4);
        chk("lives_to", 12'(lives), 12'd3);
        time_bcd = 12'h010;

        // Pause freezes play and ignores hit/goal.
        press_start();
        press_pause();
        chk("st_pause", 12'(state), 12'd2);
        chk("en_pause", 12'(count_en), 12'd0);
        hit = 1'b1;
        cyc();
        hit = 1'b0;
        goal = 1'b1;
        cyc();
        goal = 1'b0;
        cyc();
        chk("st_paused", 12'(state), 12'd2);
        chk("lives_paused", 12'(lives), 12'd3);
        press_pause();
        chk("st_resume", 12'(state), 12'd1);
        chk("en_resume", 12'(count_en), 12'd1);

        // Pause and hit together: hit wins, pause dropped.
        pause_key = 1'b1;
        cyc();
        cyc();
        hit = 1'b1;
        cyc();
        chk("st_ph", 12'(state), 12'd1);
        chk("lives_ph", 12'(lives), 12'd2);
        pause_key = 1'b0;
        hit = 1'b0;
        repeat (2) cyc();

        // Goal and hit together: win, lives kept.
        goal = 1'b1;
        hit = 1'b1;
        cyc();
        goal = 1'b0;
        hit = 1'b0;
        chk("st_gh", 12'(state), 12'd3);
        chk("lives_gh", 12'(lives), 12'd2);

        // Reset mid-round.
        press_start();
        async_reset();
        repeat (2) cyc();

        // Random play.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(7) == 0) start_key = ~start_key;
            if ($urandom_range(9) == 0) pause_key = ~pause_key;
            if ($urandom_range(5) == 0) hit = ~hit;
            goal = ($urandom_range(40) == 0);
            v = $urandom_range(15);
            if (v == 0) begin
                time_bcd = {4'($urandom_range(9)),
                            4'($urandom_range(9, 6)),
                            4'($urandom_range(9))};
            end else begin
                time_bcd = {4'd0,
                            4'($urandom_range(5)),
                            4'($urandom_range(9))};
            end
            if ($urandom_range(700) == 0) begin
                async_reset();
            end else begin
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
